// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing defaults and pixel types
package vga_timing_pkg;

  localparam int CLK_DIV_DEF = 4;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int H_TOTAL_DEF      = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int H_SYNC_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;

  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;
  localparam int V_TOTAL_DEF      = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int V_SYNC_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Largest coordinate the colour generator will ever be asked for.
  localparam int MAX_X = H_VIS_DEF - 1;
  localparam int MAX_Y = V_VIS_DEF - 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - divides the system clock down to a one-clk pixel tick
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_scan.sv
// rtl/vga_scan.sv - VGA raster counters, coordinate request and sync/RGB output pipeline
module vga_scan
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] icolor,
  output logic [9:0]  posX,
  output logic [8:0]  posY,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] HS_LO   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_HI   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] VS_LO   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_HI   = 10'(V_VIS + V_FP + V_SYNC);

  logic       tick;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [8:0] pos_y_q, pos_y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       frame_start_q, frame_start_d;
  rgb_t       rgb_q, rgb_d;
  logic       h_wrap, v_wrap, visible;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Coordinates track the new counter values; syncs and RGB are built from the
  // pixel just left, so they trail posX/posY by one tick as the colour source does.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    h_wrap        = (hcount_q == H_LAST);
    v_wrap        = (vcount_q == V_LAST);
    visible       = (hcount_q < H_VIS_L) && (vcount_q < V_VIS_L);
    if (tick) begin
      hcount_d = h_wrap ? '0 : hcount_q + 10'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + 10'd1;
      end
      pos_x_d       = (hcount_d < H_VIS_L) ? hcount_d : '0;
      pos_y_d       = (vcount_d < V_VIS_L) ? vcount_d[8:0] : '0;
      rgb_d         = visible ? rgb_t'(icolor) : '0;
      hs_d          = !in_span(hcount_q, HS_LO, HS_HI);
      vs_d          = !in_span(vcount_q, VS_LO, VS_HI);
      frame_start_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign posX        = pos_x_q;
  assign posY        = pos_y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign r           = rgb_q.r;
  assign g           = rgb_q.g;
  assign b           = rgb_q.b;
  assign frame_start = frame_start_q;

endmodule
